// File: rtl/adder_pipe_char.sv
// Elastic pipelined add/subtract unit with valid/ready handshake and
// saturating operand/result toggle counters for energy characterization.
module adder_pipe_char #(
    parameter int N      = 21,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     input1,
    input  logic [N-1:0]     input2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] toggle_in,
    output logic [CNT_W-1:0] toggle_out,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int IW = $clog2(2*N+1);
    localparam int AW = CNT_W + IW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    function automatic logic [IW-1:0] popcnt(input logic [N-1:0] v);
        logic [IW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + IW'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [IW-1:0]    b);
        logic [AW-1:0] s;
        s = AW'(a) + AW'(b);
        return (s > AW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    logic [STAGES-1:0] vld_q, vld_d, adv, load;
    res_t [STAGES-1:0] stg_q;
    res_t              res_d;
    logic [N-1:0]      b_eff;
    logic [N:0]        r;
    logic              in_xfer, out_xfer;

    logic [N-1:0]      prev1_q, prev1_d, prev2_q, prev2_d, prevs_q, prevs_d;
    logic [CNT_W-1:0]  tin_q, tin_d, tout_q, tout_d, xfer_q, xfer_d;

    always_comb begin
        b_eff     = sub ? ~input2 : input2;
        r         = {1'b0, input1} + {1'b0, b_eff} + {{N{1'b0}}, sub};
        res_d.sum = r[N-1:0];
        res_d.cout = r[N];
        res_d.ovf = (input1[N-1] == b_eff[N-1]) & (r[N-1] != input1[N-1]);
    end

    // A stage advances unless every stage above it is full and the output stalls;
    // written flat so no stage's advance feeds back into the same vector.
    always_comb begin
        logic full_above;
        full_above = 1'b1;
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            full_above = 1'b1;
            for (int j = k + 1; j < STAGES; j++) full_above = full_above & vld_q[j];
            adv[k] = vld_q[k] & (out_ready | ~full_above);
        end
    end

    assign in_ready = ~vld_q[0] | adv[0];
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = adv[STAGES-1];

    always_comb begin
        load = '0;
        load[0] = in_xfer;
        for (int k = 1; k < STAGES; k++) load[k] = adv[k-1];
        vld_d = load | (vld_q & ~adv);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            stg_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (load[0]) stg_q[0] <= res_d;
            for (int k = 1; k < STAGES; k++)
                if (load[k]) stg_q[k] <= stg_q[k-1];
        end
    end

    // Clear beats a coincident increment, but the prev registers still track.
    always_comb begin
        prev1_d = prev1_q;
        prev2_d = prev2_q;
        prevs_d = prevs_q;
        tin_d   = tin_q;
        tout_d  = tout_q;
        xfer_d  = xfer_q;
        if (in_xfer) begin
            prev1_d = input1;
            prev2_d = input2;
            tin_d   = sat_add(tin_q, popcnt(input1 ^ prev1_q) + popcnt(input2 ^ prev2_q));
            xfer_d  = sat_add(xfer_q, IW'(1));
        end
        if (out_xfer) begin
            prevs_d = stg_q[STAGES-1].sum;
            tout_d  = sat_add(tout_q, popcnt(stg_q[STAGES-1].sum ^ prevs_q));
        end
        if (clr_stats) begin
            tin_d  = '0;
            tout_d = '0;
            xfer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev1_q <= '0;
            prev2_q <= '0;
            prevs_q <= '0;
            tin_q   <= '0;
            tout_q  <= '0;
            xfer_q  <= '0;
        end else begin
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
            prevs_q <= prevs_d;
            tin_q   <= tin_d;
            tout_q  <= tout_d;
            xfer_q  <= xfer_d;
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign sum        = stg_q[STAGES-1].sum;
    assign cout       = stg_q[STAGES-1].cout;
    assign ovf        = stg_q[STAGES-1].ovf;
    assign toggle_in  = tin_q;
    assign toggle_out = tout_q;
    assign xfer_cnt   = xfer_q;

endmodule

// File: tb/tb_adder_pipe_char.sv
// Randomized + directed bench for adder_pipe_char: a queue-based reference of the
// elastic pipeline plus arithmetic/toggle models, checked with immediate assertions.
module tb_adder_pipe_char;

    localparam int N   = 21;
    localparam int S   = 2;
    localparam int CW  = 32;
    localparam int CW4 = 4;
    localparam logic [N-1:0] MASK = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0, clr_stats = 1'b0;
    logic [N-1:0] input1 = '0, input2 = '0;

    logic in_ready, out_valid, cout, ovf;
    logic [N-1:0] sum;
    logic [CW-1:0] toggle_in, toggle_out, xfer_cnt;
    logic in_ready_b, out_valid_b, cout_b, ovf_b;
    logic [N-1:0] sum_b;
    logic [CW4-1:0] toggle_in_b, toggle_out_b, xfer_cnt_b;

    adder_pipe_char #(.N(N), .STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .clr_stats(clr_stats),
        .toggle_in(toggle_in), .toggle_out(toggle_out), .xfer_cnt(xfer_cnt)
    );

    // Narrow-counter copy on the same stimulus exercises saturation.
    adder_pipe_char #(.N(N), .STAGES(S), .CNT_W(CW4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .input1(input1), .input2(input2), .sub(sub),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .sum(sum_b), .cout(cout_b), .ovf(ovf_b), .clr_stats(clr_stats),
        .toggle_in(toggle_in_b), .toggle_out(toggle_out_b), .xfer_cnt(xfer_cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        longint       acc;
    } exp_t;

    exp_t q[$];
    longint m_tin = 0, m_tout = 0, m_x = 0, cyc = 0;
    logic [N-1:0] m_p1 = '0, m_p2 = '0, m_ps = '0;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint satv(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Plain integer arithmetic: unsigned result for sum/cout, signed range for ovf.
    function automatic exp_t ref_op(input longint a, input longint b, input bit s);
        exp_t e;
        longint r, sa, sb, sr, half;
        half = longint'(1) << (N - 1);
        r = s ? (a + (longint'(1) << N) - b) : (a + b);
        sa = (a >= half) ? a - (longint'(1) << N) : a;
        sb = (b >= half) ? b - (longint'(1) << N) : b;
        sr = s ? sa - sb : sa + sb;
        e.sum  = N'(r);
        e.cout = r[N];
        e.ovf  = (sr > half - 1) || (sr < -half);
        e.acc  = 0;
        return e;
    endfunction

    task automatic cycle();
        bit exp_rdy, exp_vld, in_x, out_x;
        exp_t e;
        in_x = 1'b0;
        out_x = 1'b0;
        #1;
        if (!rst) begin
            exp_rdy = (q.size() < S) || out_ready;
            exp_vld = (q.size() > 0) && (cyc - q[0].acc >= S - 1);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(exp_vld));
            chk("out_valid_b", 64'(out_valid_b), 64'(exp_vld));
            if (exp_vld) begin
                chk("sum", 64'(sum), 64'(q[0].sum));
                chk("cout", 64'(cout), 64'(q[0].cout));
                chk("ovf", 64'(ovf), 64'(q[0].ovf));
            end
            in_x  = in_valid && exp_rdy;
            out_x = exp_vld && out_ready;
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            m_tin = 0; m_tout = 0; m_x = 0;
            m_p1 = '0; m_p2 = '0; m_ps = '0;
        end else begin
            if (out_x) begin
                m_tout += $countones(q[0].sum ^ m_ps);
                m_ps = q[0].sum;
                void'(q.pop_front());
            end
            if (in_x) begin
                e = ref_op(longint'(input1), longint'(input2), sub);
                e.acc = cyc;
                q.push_back(e);
                m_tin += $countones(input1 ^ m_p1) + $countones(input2 ^ m_p2);
                m_p1 = input1;
                m_p2 = input2;
                m_x++;
            end
            if (clr_stats) begin
                m_tin = 0; m_tout = 0; m_x = 0;
            end
        end
        @(negedge clk);
        chk("toggle_in", 64'(toggle_in), 64'(satv(m_tin, CW)));
        chk("toggle_out", 64'(toggle_out), 64'(satv(m_tout, CW)));
        chk("xfer_cnt", 64'(xfer_cnt), 64'(satv(m_x, CW)));
        chk("toggle_in_b", 64'(toggle_in_b), 64'(satv(m_tin, CW4)));
        chk("toggle_out_b", 64'(toggle_out_b), 64'(satv(m_tout, CW4)));
        chk("xfer_cnt_b", 64'(xfer_cnt_b), 64'(satv(m_x, CW4)));
    endtask

    task automatic drv(input bit v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit s, input bit ordy, input bit clr);
        in_valid = v; input1 = a; input2 = b; sub = s;
        out_ready = ordy; clr_stats = clr;
        cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) drv(0, '0, '0, 0, 0, 0);
        rst = 1'b0;
    endtask

    function automatic logic [N-1:0] pick_op();
        logic [N-1:0] c[4];
        c[0] = '0; c[1] = MASK; c[2] = N'(1) << (N - 1); c[3] = MASK >> 1;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
        return N'($urandom);
    endfunction

    initial begin
        @(negedge clk);

        // Reset then idle
        do_reset(2);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        drv(0, '0, '0, 0, 1, 0);

        // Back-to-back add/sub stream
        drv(1, 21'h1FFFFF, 21'h000001, 0, 1, 0);
        drv(1, 21'h0FFFFF, 21'h000001, 0, 1, 0);
        drv(1, 21'd5, 21'd7, 1, 1, 0);
        for (int i = 0; i < 3; i++) drv(0, '0, '0, 0, 1, 0);

        // Toggle counting from reset
        do_reset(1);
        drv(1, 21'h1FFFFF, 21'h1FFFFF, 0, 1, 0);
        chk("tog_first", 64'(toggle_in), 64'd42);
        drv(1, 21'h1FFFFF, 21'h1FFFFF, 0, 1, 0);
        chk("tog_repeat", 64'(toggle_in), 64'd42);
        chk("tog_xfer", 64'(xfer_cnt), 64'd2);
        for (int i = 0; i < 3; i++) drv(0, '0, '0, 0, 1, 0);

        // Backpressure fill then drain
        do_reset(1);
        for (int i = 0; i < 5; i++) drv(1, N'($urandom), N'($urandom), 1'($urandom), 0, 0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_xfer", 64'(xfer_cnt), 64'd2);
        for (int i = 0; i < 4; i++) drv(0, '0, '0, 0, 1, 0);

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++)
            drv($urandom_range(0, 3) != 0, pick_op(), pick_op(), 1'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

        // Reset with results in flight
        drv(1, N'($urandom), N'($urandom), 0, 0, 0);
        drv(1, N'($urandom), N'($urandom), 0, 0, 0);
        rst = 1'b1;
        drv(1, N'($urandom), N'($urandom), 0, 1, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drv(0, '0, '0, 0, 1, 0);

        // Saturation of the narrow counters and clear-during-transfer
        do_reset(1);
        for (int i = 0; i < 16; i++) drv(1, N'($urandom), N'($urandom), 0, 1, 0);
        chk("sat_xfer_b", 64'(xfer_cnt_b), 64'd15);
        chk("sat_xfer", 64'(xfer_cnt), 64'd16);
        drv(1, N'($urandom), N'($urandom), 0, 1, 1);
        chk("clr_xfer_b", 64'(xfer_cnt_b), 64'd0);
        drv(1, N'($urandom), N'($urandom), 0, 1, 0);
        chk("post_clr_xfer_b", 64'(xfer_cnt_b), 64'd1);
        for (int i = 0; i < 4; i++) drv(0, '0, '0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
